// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs, branch/memory events,
// and the stall/freeze/flush controls (perf counters with HAZARD_PERF_CNT_EN).
interface hazard_ctrl_if;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic       id_branch_op_i;
  logic [4:0] ex_rd_i;
  logic       ex_memread_i;
  logic [4:0] mem_rd_i;
  logic       mem_memread_i;
  logic       mispredict_i;
  logic       jmp_i;
  logic       dmem_busy_i;
  logic       stall_o;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       if_flush_o;
  logic       freeze_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [31:0] freeze_cnt_o;
`endif

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output id_branch_op_i, ex_rd_i, ex_memread_i,
    output mem_rd_i, mem_memread_i,
    output mispredict_i, jmp_i, dmem_busy_i,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cnt_o, flush_cnt_o, freeze_cnt_o,
`endif
    input  stall_o, pc_write_o, ifid_write_o,
    input  if_flush_o, freeze_o, state_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input  id_branch_op_i, ex_rd_i, ex_memread_i,
    input  mem_rd_i, mem_memread_i,
    input  mispredict_i, jmp_i, dmem_busy_i,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cnt_o, flush_cnt_o, freeze_cnt_o,
`endif
    output stall_o, pc_write_o, ifid_write_o,
    output if_flush_o, freeze_o, state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / load-branch stalls, IF flush on
// redirect, full freeze on dmem busy. Ports: clk, rst (async, active-high),
// hz (hazard_ctrl_if.slave). Optional macro HAZARD_PERF_CNT_EN adds counters.
module hazard_ctrl #(
  parameter int LD_BR_STALL  = 2,
  parameter int LD_USE_STALL = 1,
  parameter int CNT_W        = 2
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_STALL  = 2'd1;
  localparam logic [1:0] S_FREEZE = 2'd2;

  localparam logic [CNT_W-1:0] N_BR   = CNT_W'(LD_BR_STALL);
  localparam logic [CNT_W-1:0] N_BRM  = CNT_W'(LD_BR_STALL - 1);
  localparam logic [CNT_W-1:0] N_USE  = CNT_W'(LD_USE_STALL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       saved;
  logic [1:0]       eff;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n;
  logic             m_ex;
  logic             m_mem;
  logic             ld_br_ex;
  logic             ld_br_mem;
  logic             ld_use;
  logic             busy;
  logic             stall_c;
  logic             stall;
  logic             freeze;
  logic             flush;

  assign busy = hz.dmem_busy_i;

  assign m_ex = (hz.ex_rd_i != 5'd0) &&
    ((hz.id_use_rs1_i && hz.id_rs1_i == hz.ex_rd_i) ||
     (hz.id_use_rs2_i && hz.id_rs2_i == hz.ex_rd_i));

  assign m_mem = (hz.mem_rd_i != 5'd0) &&
    ((hz.id_use_rs1_i && hz.id_rs1_i == hz.mem_rd_i) ||
     (hz.id_use_rs2_i && hz.id_rs2_i == hz.mem_rd_i));

  // Made mutually exclusive so the one-hot decode below stays unique.
  assign ld_br_ex  = hz.id_branch_op_i & hz.ex_memread_i & m_ex;
  assign ld_br_mem = hz.id_branch_op_i & hz.mem_memread_i & m_mem
                   & ~ld_br_ex;
  assign ld_use    = ~hz.id_branch_op_i & hz.ex_memread_i & m_ex;

  always_comb begin
    n = '0;
    unique case (1'b1)
      ld_br_ex:  n = N_BR;
      ld_br_mem: n = N_BRM;
      ld_use:    n = N_USE;
      default:   n = '0;
    endcase
  end

  // Once busy drops, FREEZE behaves as the saved state in that same cycle.
  assign eff = (state == S_FREEZE) ? saved : state;

  always_comb begin
    stall_c = 1'b0;
    unique case (eff)
      S_STALL: stall_c = ~busy;
      default: stall_c = ~busy & (n != '0);
    endcase
  end

  assign stall  = stall_c & ~rst;
  assign freeze = busy & ~rst;
  assign flush  = (hz.mispredict_i | hz.jmp_i) & ~stall & ~freeze & ~rst;

  assign hz.stall_o      = stall;
  assign hz.freeze_o     = freeze;
  assign hz.if_flush_o   = flush;
  assign hz.pc_write_o   = ~(stall | freeze);
  assign hz.ifid_write_o = ~(stall | freeze);
  assign hz.state_o      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      saved <= S_RUN;
      cnt   <= '0;
    end else if (busy) begin
      if (state != S_FREEZE) saved <= state;
      state <= S_FREEZE;
    end else begin
      unique case (eff)
        S_STALL: begin
          if (cnt == ONE) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            state <= S_STALL;
            cnt   <= cnt - ONE;
          end
        end
        default: begin
          if (n > ONE) begin
            cnt   <= n - ONE;
            state <= S_STALL;
          end else begin
            state <= S_RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall)  stall_cnt  <= stall_cnt + 32'd1;
      if (flush)  flush_cnt  <= flush_cnt + 32'd1;
      if (freeze) freeze_cnt <= freeze_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt_o  = stall_cnt;
  assign hz.flush_cnt_o  = flush_cnt;
  assign hz.freeze_cnt_o = freeze_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: vector table, hand sequences for multi-cycle
// cases, and randomized stimulus against a behavioural model.
module tb_hazard_ctrl;

  localparam int LD_BR  = 2;
  localparam int LD_USE = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl_if hz();

  hazard_ctrl #(
    .LD_BR_STALL (LD_BR),
    .LD_USE_STALL(LD_USE),
    .CNT_W       (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic [4:0] exrd;
    logic       exl;
    logic [4:0] memrd;
    logic       meml;
    logic       mp;
    logic       jmp;
    logic       busy;
    logic       stall;
    logic       pcw;
    logic       flush;
    logic       frz;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic add(input string nm,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic br,
                     input logic [4:0] exrd, input logic exl,
                     input logic [4:0] memrd, input logic meml,
                     input logic mp, input logic jmp, input logic busy,
                     input logic stall, input logic pcw,
                     input logic flush, input logic frz);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.br = br; v.exrd = exrd; v.exl = exl; v.memrd = memrd;
    v.meml = meml; v.mp = mp; v.jmp = jmp; v.busy = busy;
    v.stall = stall; v.pcw = pcw; v.flush = flush; v.frz = frz;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    hz.id_rs1_i       = v.rs1;
    hz.id_rs2_i       = v.rs2;
    hz.id_use_rs1_i   = v.u1;
    hz.id_use_rs2_i   = v.u2;
    hz.id_branch_op_i = v.br;
    hz.ex_rd_i        = v.exrd;
    hz.ex_memread_i   = v.exl;
    hz.mem_rd_i       = v.memrd;
    hz.mem_memread_i  = v.meml;
    hz.mispredict_i   = v.mp;
    hz.jmp_i          = v.jmp;
    hz.dmem_busy_i    = v.busy;
  endtask

  task automatic idle();
    vec_t v;
    v.name = "idle"; v.rs1 = 0; v.rs2 = 0; v.u1 = 0; v.u2 = 0;
    v.br = 0; v.exrd = 0; v.exl = 0; v.memrd = 0; v.meml = 0;
    v.mp = 0; v.jmp = 0; v.busy = 0;
    v.stall = 0; v.pcw = 1; v.flush = 0; v.frz = 0;
    drive(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ld_branch(input logic mp);
    idle();
    hz.id_branch_op_i = 1'b1;
    hz.id_rs1_i       = 5'd7;
    hz.id_use_rs1_i   = 1'b1;
    hz.ex_rd_i        = 5'd7;
    hz.ex_memread_i   = 1'b1;
    hz.mispredict_i   = mp;
  endtask

  // Stall count from the hazard rules, as plain arithmetic.
  function automatic int model_n(
    input int rs1, input int rs2, input bit u1, input bit u2,
    input bit br, input int exrd, input bit exl,
    input int memrd, input bit meml);
    bit mex;
    bit mmem;
    mex  = exrd != 0 && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
    mmem = memrd != 0 && ((u1 && rs1 == memrd) || (u2 && rs2 == memrd));
    if (br && exl && mex) return LD_BR;
    if (br && meml && mmem) return LD_BR - 1;
    if (!br && exl && mex) return LD_USE;
    return 0;
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    #1;
    chk("rst_state", hz.state_o, 0);
    chk("rst_stall", hz.stall_o, 0);
    chk("rst_freeze", hz.freeze_o, 0);
    chk("rst_flush", hz.if_flush_o, 0);
    chk("rst_pcw", hz.pc_write_o, 1);
    chk("rst_ifidw", hz.ifid_write_o, 1);
    @(negedge clk);
    rst = 1'b0;

    //   name        rs1 rs2 u1 u2 br exrd exl memrd meml mp jmp bsy  st pw fl fz
    add("ld_use",     5,  0, 1, 0, 0,  5,  1,  0,   0,  0, 0,  0,  1, 0, 0, 0);
    add("ld_x0",      0,  0, 1, 1, 0,  0,  1,  0,   0,  0, 0,  0,  0, 1, 0, 0);
    add("alu_x5",     5,  0, 1, 0, 0,  5,  0,  0,   0,  0, 0,  0,  0, 1, 0, 0);
    add("ld_br_mp",   0,  7, 0, 1, 1,  7,  1,  0,   0,  1, 0,  0,  1, 0, 0, 0);
    add("ld_br_mem",  7,  0, 1, 0, 1,  0,  0,  7,   1,  0, 0,  0,  1, 0, 0, 0);
    add("ld_mem_use", 7,  0, 1, 0, 0,  0,  0,  7,   1,  0, 0,  0,  0, 1, 0, 0);
    add("jmp",        0,  0, 0, 0, 0,  0,  0,  0,   0,  0, 1,  0,  0, 1, 1, 0);
    add("mispredict", 3,  4, 1, 1, 1,  9,  0,  0,   0,  1, 0,  0,  0, 1, 1, 0);
    add("busy_jmp",   5,  0, 1, 0, 0,  5,  1,  0,   0,  0, 1,  1,  0, 0, 0, 1);
    add("ld_unused",  5,  0, 0, 0, 0,  5,  1,  0,   0,  0, 0,  0,  0, 1, 0, 0);
    add("ld_use_rs2", 1,  6, 1, 1, 0,  6,  1,  0,   0,  0, 1,  0,  1, 0, 0, 0);

    foreach (vq[i]) begin
      do_reset();
      drive(vq[i]);
      #1;
      chk({vq[i].name, "_stall"}, hz.stall_o, vq[i].stall);
      chk({vq[i].name, "_pcw"}, hz.pc_write_o, vq[i].pcw);
      chk({vq[i].name, "_flush"}, hz.if_flush_o, vq[i].flush);
      chk({vq[i].name, "_freeze"}, hz.freeze_o, vq[i].frz);
      idle();
    end

    // Load-use: exactly one stall cycle, no STALL state.
    do_reset();
    idle();
    hz.id_rs1_i = 5'd5; hz.id_use_rs1_i = 1'b1;
    hz.ex_rd_i = 5'd5; hz.ex_memread_i = 1'b1;
    #1;
    chk("lu_c1_stall", hz.stall_o, 1);
    chk("lu_c1_pcw", hz.pc_write_o, 0);
    @(negedge clk);
    hz.ex_memread_i = 1'b0;
    #1;
    chk("lu_c2_state", hz.state_o, 0);
    chk("lu_c2_stall", hz.stall_o, 0);

    // Load-branch: two stall cycles, flush held off, then released.
    do_reset();
    ld_branch(1'b1);
    #1;
    chk("lb_c1_stall", hz.stall_o, 1);
    chk("lb_c1_flush", hz.if_flush_o, 0);
    @(negedge clk);
    #1;
    chk("lb_c2_state", hz.state_o, 1);
    chk("lb_c2_stall", hz.stall_o, 1);
    chk("lb_c2_flush", hz.if_flush_o, 0);
    @(negedge clk);
    hz.ex_memread_i = 1'b0;
    #1;
    chk("lb_c3_state", hz.state_o, 0);
    chk("lb_c3_stall", hz.stall_o, 0);
    chk("lb_c3_flush", hz.if_flush_o, 1);
    @(negedge clk);
    hz.mispredict_i = 1'b0;
    #1;
    chk("lb_c4_flush", hz.if_flush_o, 0);

    // Busy during the second stall cycle: freeze 3, then 1 stall.
    do_reset();
    ld_branch(1'b0);
    #1;
    chk("fz_c1_stall", hz.stall_o, 1);
    @(negedge clk);
    hz.ex_memread_i = 1'b0;
    hz.dmem_busy_i  = 1'b1;
    #1;
    chk("fz_c2_freeze", hz.freeze_o, 1);
    chk("fz_c2_stall", hz.stall_o, 0);
    chk("fz_c2_pcw", hz.pc_write_o, 0);
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("fz_c%0d_freeze", k), hz.freeze_o, 1);
      chk($sformatf("fz_c%0d_state", k), hz.state_o, 2);
      chk($sformatf("fz_c%0d_ifidw", k), hz.ifid_write_o, 0);
    end
    @(negedge clk);
    hz.dmem_busy_i = 1'b0;
    #1;
    chk("fz_c5_freeze", hz.freeze_o, 0);
    chk("fz_c5_stall", hz.stall_o, 1);
    @(negedge clk);
    #1;
    chk("fz_c6_state", hz.state_o, 0);
    chk("fz_c6_stall", hz.stall_o, 0);
    chk("fz_c6_pcw", hz.pc_write_o, 1);

    // Reset in the middle of a stall.
    do_reset();
    ld_branch(1'b0);
    @(negedge clk);
    #1;
    chk("rs_pre_state", hz.state_o, 1);
    rst = 1'b1;
    #1;
    chk("rs_state", hz.state_o, 0);
    chk("rs_stall", hz.stall_o, 0);
    chk("rs_pcw", hz.pc_write_o, 1);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rs_after_state", hz.state_o, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("pc_rst_stall", hz.stall_cnt_o, 0);
    chk("pc_rst_flush", hz.flush_cnt_o, 0);
    chk("pc_rst_freeze", hz.freeze_cnt_o, 0);
    ld_branch(1'b0);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    chk("pc_lb_stall", hz.stall_cnt_o, 2);
    chk("pc_lb_flush", hz.flush_cnt_o, 0);
`endif

    // Randomized run against the behavioural model.
    begin
      int rem;
      bit bprev;
      int e_st_cnt;
      int e_fl_cnt;
      int e_fz_cnt;
      do_reset();
      rem = 0; bprev = 0;
      e_st_cnt = 0; e_fl_cnt = 0; e_fz_cnt = 0;
      for (int c = 0; c < 600; c++) begin
        int rs1, rs2, exrd, memrd, n;
        bit u1, u2, br, exl, meml, mp, jmp, busy;
        bit e_stall, e_frz, e_flush;
        int e_state;
        @(negedge clk);
        rs1 = $urandom_range(0, 3);
        rs2 = $urandom_range(0, 3);
        exrd = $urandom_range(0, 3);
        memrd = $urandom_range(0, 3);
        u1 = 1'($urandom); u2 = 1'($urandom);
        br = 1'($urandom);
        exl = 1'($urandom); meml = 1'($urandom);
        mp = ($urandom_range(0, 4) == 0);
        jmp = ($urandom_range(0, 4) == 0);
        busy = ($urandom_range(0, 5) == 0);
        hz.id_rs1_i = 5'(rs1); hz.id_rs2_i = 5'(rs2);
        hz.id_use_rs1_i = u1; hz.id_use_rs2_i = u2;
        hz.id_branch_op_i = br;
        hz.ex_rd_i = 5'(exrd); hz.ex_memread_i = exl;
        hz.mem_rd_i = 5'(memrd); hz.mem_memread_i = meml;
        hz.mispredict_i = mp; hz.jmp_i = jmp;
        hz.dmem_busy_i = busy;
        n = model_n(rs1, rs2, u1, u2, br, exrd, exl, memrd, meml);
        e_frz   = busy;
        e_stall = !busy && (rem > 0 || n > 0);
        e_flush = (mp || jmp) && !e_stall && !e_frz;
        e_state = bprev ? 2 : (rem > 0 ? 1 : 0);
        #1;
        chk("rnd_stall", hz.stall_o, 32'(e_stall));
        chk("rnd_freeze", hz.freeze_o, 32'(e_frz));
        chk("rnd_flush", hz.if_flush_o, 32'(e_flush));
        chk("rnd_pcw", hz.pc_write_o, 32'(!(e_stall || e_frz)));
        chk("rnd_state", hz.state_o, 32'(e_state));
        if (e_stall) e_st_cnt++;
        if (e_flush) e_fl_cnt++;
        if (e_frz) e_fz_cnt++;
        if (!busy) begin
          if (rem > 0) rem--;
          else if (n > 0) rem = n - 1;
        end
        bprev = busy;
      end
      @(negedge clk);
      idle();
`ifdef HAZARD_PERF_CNT_EN
      #1;
      chk("rnd_stall_cnt", hz.stall_cnt_o, 32'(e_st_cnt));
      chk("rnd_flush_cnt", hz.flush_cnt_o, 32'(e_fl_cnt));
      chk("rnd_freeze_cnt", hz.freeze_cnt_o, 32'(e_fz_cnt));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
